// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one registered one-hot grant among `requesters` clients,
// with a hold-time limit that hands the resource on when others are waiting.
module round_robin_arbiter #(
  parameter int requesters = 4,
  parameter int max_hold   = 16,
  localparam int id_w      = $clog2(requesters > 2 ? requesters : 2),
  localparam int cnt_w     = $clog2(max_hold > 2 ? max_hold : 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [requesters-1:0] req,
  output logic [requesters-1:0] gnt,
  output logic [id_w-1:0]       gnt_id,
  output logic                  gnt_valid,
  output logic                  preempt
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [cnt_w-1:0] cnt_cap   = cnt_w'(max_hold - 1);
  localparam logic [id_w-1:0]  last_init = id_w'(requesters - 1);

  state_e                state_q, state_d;
  logic [requesters-1:0] gnt_q, gnt_d;
  logic [id_w-1:0]       id_q, id_d;
  logic [id_w-1:0]       last_q, last_d;
  logic [cnt_w-1:0]      cnt_q, cnt_d;
  logic                  preempt_q, preempt_d;
  logic [requesters-1:0] cand;
  logic [id_w:0]         hit;

  // Returns {found, index} of the first set bit scanning from start+1 and
  // wrapping around to start itself.
  function automatic logic [id_w:0] find_next(input logic [requesters-1:0] vec,
                                              input logic [id_w-1:0]       start);
    logic [id_w:0] res;
    int            idx;
    res = '0;
    for (int k = 1; k <= requesters; k++) begin
      idx = int'(start) + k;
      if (idx >= requesters) idx -= requesters;
      if (!res[id_w] && vec[idx]) res = {1'b1, id_w'(idx)};
    end
    return res;
  endfunction

  // While granting, last equals the owner, so masking it leaves "other" requesters.
  always_comb begin
    cand = req;
    if (state_q == GRANT) cand[id_q] = 1'b0;
    hit = find_next(cand, last_q);
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit[id_w]) begin
          state_d = GRANT;
          id_d    = hit[id_w-1:0];
          last_d  = hit[id_w-1:0];
          cnt_d   = '0;
          gnt_d   = '0;
          gnt_d[hit[id_w-1:0]] = 1'b1;
        end
      end
      GRANT: begin
        if (!req[id_q] || (cnt_q == cnt_cap && hit[id_w])) begin
          if (hit[id_w]) begin
            id_d      = hit[id_w-1:0];
            last_d    = hit[id_w-1:0];
            cnt_d     = '0;
            gnt_d     = '0;
            gnt_d[hit[id_w-1:0]] = 1'b1;
            preempt_d = req[id_q];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            cnt_d   = '0;
          end
        end else if (cnt_q != cnt_cap) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      last_q    <= last_init;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == GRANT);
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter with 4 requesters and a hold limit of 4.
module tb_round_robin_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  round_robin_arbiter #(.requesters(4), .max_hold(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation word: {gnt, gnt_id, gnt_valid, preempt}.
  function automatic logic [7:0] mk(input logic [3:0] g, input logic [1:0] id, input logic p);
    return {g, id, |g, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0;
    req   = '0;
    #1;
    exp = mk(4'b0000, 2'd0, 1'b0);
    checks++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== exp) begin
      failures++;
      $display("FAIL reset_asserted: got %b want %b", {gnt, gnt_id, gnt_valid, preempt}, exp);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== exp) begin
      failures++;
      $display("FAIL reset_idle: got %b want %b", {gnt, gnt_id, gnt_valid, preempt}, exp);
    end
  endtask

  task automatic test_handover();
    logic [3:0] reqs [3] = '{4'b1010, 4'b1000, 4'b0000};
    logic [7:0] exps [3];
    exps = '{mk(4'b0010, 2'd1, 1'b0), mk(4'b1000, 2'd3, 1'b0), mk(4'b0000, 2'd0, 1'b0)};
    for (int i = 0; i < 3; i++) begin
      req = reqs[i];
      step();
      checks++;
      if ({gnt, gnt_id, gnt_valid, preempt} !== exps[i]) begin
        failures++;
        $display("FAIL handover step %0d: got %b want %b", i, {gnt, gnt_id, gnt_valid, preempt}, exps[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] reqs [6] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000};
    logic [7:0] exps [6];
    exps = '{mk(4'b0001, 2'd0, 1'b0), mk(4'b0010, 2'd1, 1'b0), mk(4'b0100, 2'd2, 1'b0),
             mk(4'b1000, 2'd3, 1'b0), mk(4'b0001, 2'd0, 1'b0), mk(4'b0000, 2'd0, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      req = reqs[i];
      step();
      checks++;
      if ({gnt, gnt_id, gnt_valid, preempt} !== exps[i]) begin
        failures++;
        $display("FAIL fairness step %0d: got %b want %b", i, {gnt, gnt_id, gnt_valid, preempt}, exps[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exps [11];
    exps = '{mk(4'b0001, 2'd0, 1'b0), mk(4'b0001, 2'd0, 1'b0), mk(4'b0001, 2'd0, 1'b0),
             mk(4'b0001, 2'd0, 1'b0), mk(4'b0010, 2'd1, 1'b1), mk(4'b0010, 2'd1, 1'b0),
             mk(4'b0010, 2'd1, 1'b0), mk(4'b0010, 2'd1, 1'b0), mk(4'b0001, 2'd0, 1'b1),
             mk(4'b0001, 2'd0, 1'b0), mk(4'b0000, 2'd0, 1'b0)};
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) req = 4'b0000;
      step();
      checks++;
      if ({gnt, gnt_id, gnt_valid, preempt} !== exps[i]) begin
        failures++;
        $display("FAIL timeout step %0d: got %b want %b", i, {gnt, gnt_id, gnt_valid, preempt}, exps[i]);
      end
    end
  endtask

  task automatic test_lone_holder();
    logic [7:0] exp;
    exp = mk(4'b0100, 2'd2, 1'b0);
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({gnt, gnt_id, gnt_valid, preempt} !== exp) begin
        failures++;
        $display("FAIL lone_holder cycle %0d: got %b want %b", i, {gnt, gnt_id, gnt_valid, preempt}, exp);
      end
    end
  endtask

  task automatic test_release_idle();
    logic [7:0] exp;
    req = 4'b0000;
    step();
    exp = mk(4'b0000, 2'd0, 1'b0);
    checks++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== exp) begin
      failures++;
      $display("FAIL release_idle: got %b want %b", {gnt, gnt_id, gnt_valid, preempt}, exp);
    end
    req = 4'b1111;
    step();
    exp = mk(4'b1000, 2'd3, 1'b0);
    checks++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== exp) begin
      failures++;
      $display("FAIL release_regrant: got %b want %b", {gnt, gnt_id, gnt_valid, preempt}, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    #2;
    rst_n = 1'b0;
    #1;
    exp = mk(4'b0000, 2'd0, 1'b0);
    checks++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== exp) begin
      failures++;
      $display("FAIL async_reset_drop: got %b want %b", {gnt, gnt_id, gnt_valid, preempt}, exp);
    end
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== exp) begin
      failures++;
      $display("FAIL async_reset_released: got %b want %b", {gnt, gnt_id, gnt_valid, preempt}, exp);
    end
    step();
    exp = mk(4'b0001, 2'd0, 1'b0);
    checks++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== exp) begin
      failures++;
      $display("FAIL async_reset_regrant: got %b want %b", {gnt, gnt_id, gnt_valid, preempt}, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    test_reset();
    test_handover();
    test_fairness();
    test_timeout();
    test_lone_holder();
    test_release_idle();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
